// File: rtl/counter_run_controller.sv
// counter_run_controller
//   Sequencing FSM for the debounced up/down display counter. Converts the
//   debounced run/load buttons, the clkdiv tick and the up_down switch into
//   single-cycle commands (step / clear / load) for the BCD counter. It owns
//   run/pause, terminal-count handling and the thousands-digit preset.
//
// Ports
//   clk        in   1   system clock, posedge
//   rst        in   1   synchronous reset, active-low
//   tick       in   1   one-cycle count strobe from clkdiv
//   btn_run    in   1   debounced run/pause button (level)
//   btn_load   in   1   debounced load button (level)
//   up_down    in   1   direction switch, 1 = up
//   data_in    in   4   preset digit for the thousands position
//   count_val  in   CW  current counter value (binary)
//   cnt_en     out  1   one-cycle step command
//   cnt_up     out  1   direction to the counter, 1 = up
//   cnt_clr    out  1   one-cycle clear-to-zero command
//   cnt_load   out  1   one-cycle load command
//   load_val   out  CW  value to load, valid while cnt_load = 1
//   state      out  3   FSM state (debug)
module counter_run_controller #(
  parameter int CW         = 14,
  parameter int MAX_COUNT  = 9999,
  parameter bit WRAP       = 1'b1,
  parameter int LOAD_SCALE = 1000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          btn_run,
  input  logic          btn_load,
  input  logic          up_down,
  input  logic [3:0]    data_in,
  input  logic [CW-1:0] count_val,
  output logic          cnt_en,
  output logic          cnt_up,
  output logic          cnt_clr,
  output logic          cnt_load,
  output logic [CW-1:0] load_val,
  output logic [2:0]    state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_LOAD  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [CW-1:0] MAX_V = CW'(MAX_COUNT);

  state_t state_q;
  logic   run_q;
  logic   load_q;
  logic   run_rise;
  logic   load_rise;

  // Thousands-digit preset; digits above 9 clamp to 9 so the display never
  // shows a non-decimal digit.
  function automatic logic [CW-1:0] preset(input logic [3:0] d);
    logic [3:0]    dig;
    logic [CW-1:0] prod;
    dig  = (d > 4'd9) ? 4'd9 : d;
    prod = CW'(dig) * CW'(LOAD_SCALE);
    return prod;
  endfunction

  // A held button produces exactly one event on its rising edge.
  assign run_rise  = btn_run  & ~run_q;
  assign load_rise = btn_load & ~load_q;
  assign state     = state_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      run_q    <= 1'b0;
      load_q   <= 1'b0;
      cnt_en   <= 1'b0;
      cnt_clr  <= 1'b0;
      cnt_load <= 1'b0;
      cnt_up   <= 1'b1;
      load_val <= '0;
    end else begin
      run_q    <= btn_run;
      load_q   <= btn_load;
      // Command strobes default low so each lasts exactly one cycle.
      cnt_en   <= 1'b0;
      cnt_clr  <= 1'b0;
      cnt_load <= 1'b0;
      // Direction only changes on a step so it is stable between steps.
      if (tick) cnt_up <= up_down;

      case (state_q)
        // Load lasts one cycle; any events seen during it are dropped.
        S_LOAD: state_q <= S_IDLE;

        S_IDLE, S_RUN, S_PAUSE, S_HALT: begin
          if (load_rise) begin
            state_q  <= S_LOAD;
            cnt_load <= 1'b1;
            load_val <= preset(data_in);
          end else if (run_rise) begin
            case (state_q)
              S_IDLE:  state_q <= S_RUN;
              S_RUN:   state_q <= S_PAUSE;
              S_PAUSE: state_q <= S_RUN;
              default: begin
                // Leaving HALT restarts the count from zero.
                state_q <= S_IDLE;
                cnt_clr <= 1'b1;
              end
            endcase
          end else if (tick && state_q == S_RUN) begin
            if (up_down) begin
              if (count_val < MAX_V) cnt_en  <= 1'b1;
              else if (WRAP)         cnt_clr <= 1'b1;
              else                   state_q <= S_HALT;
            end else begin
              if (count_val != '0) cnt_en <= 1'b1;
              else if (WRAP) begin
                cnt_load <= 1'b1;
                load_val <= MAX_V;
              end else begin
                state_q <= S_HALT;
              end
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_run_controller.sv
module tb_counter_run_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic        btn_run = 1'b0;
  logic        btn_load = 1'b0;
  logic        up_down = 1'b0;
  logic [3:0]  data_in = 4'd0;
  logic [13:0] count_val = 14'd0;

  logic        en_w, up_w, clr_w, ld_w, en_h, up_h, clr_h, ld_h;
  logic [13:0] lv_w, lv_h;
  logic [2:0]  st_w, st_h;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  counter_run_controller #(.CW(14), .MAX_COUNT(9999), .WRAP(1'b1), .LOAD_SCALE(1000)) dut_w (
    .clk(clk), .rst(rst), .tick(tick), .btn_run(btn_run), .btn_load(btn_load),
    .up_down(up_down), .data_in(data_in), .count_val(count_val),
    .cnt_en(en_w), .cnt_up(up_w), .cnt_clr(clr_w), .cnt_load(ld_w),
    .load_val(lv_w), .state(st_w));

  counter_run_controller #(.CW(14), .MAX_COUNT(9999), .WRAP(1'b0), .LOAD_SCALE(1000)) dut_h (
    .clk(clk), .rst(rst), .tick(tick), .btn_run(btn_run), .btn_load(btn_load),
    .up_down(up_down), .data_in(data_in), .count_val(count_val),
    .cnt_en(en_h), .cnt_up(up_h), .cnt_clr(clr_h), .cnt_load(ld_h),
    .load_val(lv_h), .state(st_h));

  // Behavioural reference: modes numbered as the state output reports them.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LOAD = 3, M_HALT = 4;

  typedef struct {
    int mode;
    bit rp, lp, en, clr, ld, up;
    int lv;
  } mdl_t;

  mdl_t mw, mh;

  function automatic mdl_t mstep(mdl_t m, bit wrap);
    mdl_t n;
    bit rr, lr;
    n = m;
    if (!rst) begin
      n.mode = M_IDLE; n.rp = 0; n.lp = 0; n.en = 0; n.clr = 0; n.ld = 0;
      n.up = 1; n.lv = 0;
      return n;
    end
    rr = btn_run && !m.rp;
    lr = btn_load && !m.lp;
    n.rp = btn_run; n.lp = btn_load;
    n.en = 0; n.clr = 0; n.ld = 0;
    if (tick) n.up = up_down;
    if (m.mode == M_LOAD) begin
      n.mode = M_IDLE;
    end else if (lr) begin
      n.mode = M_LOAD;
      n.ld = 1;
      n.lv = ((data_in > 9) ? 9 : int'(data_in)) * 1000;
    end else if (rr) begin
      if (m.mode == M_RUN) n.mode = M_PAUSE;
      else if (m.mode == M_HALT) begin n.mode = M_IDLE; n.clr = 1; end
      else n.mode = M_RUN;
    end else if (tick && m.mode == M_RUN) begin
      if (up_down) begin
        if (int'(count_val) < 9999) n.en = 1;
        else if (wrap) n.clr = 1;
        else n.mode = M_HALT;
      end else begin
        if (count_val > 0) n.en = 1;
        else if (wrap) begin n.ld = 1; n.lv = 9999; end
        else n.mode = M_HALT;
      end
    end
    return n;
  endfunction

  function automatic logic [20:0] mpack(mdl_t m);
    return {3'(m.mode), m.en, m.clr, m.ld, m.up, 14'(m.lv)};
  endfunction

  task automatic check(input string name, input logic [20:0] got, input logic [20:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got st=%0d en=%0b clr=%0b ld=%0b up=%0b lv=%0d, want st=%0d en=%0b clr=%0b ld=%0b up=%0b lv=%0d",
               name, got[20:18], got[17], got[16], got[15], got[14], got[13:0],
               exp[20:18], exp[17], exp[16], exp[15], exp[14], exp[13:0]);
    end
  endtask

  // One clock: inputs already driven; after the edge advance the model and compare.
  task automatic step(input string tag);
    @(posedge clk);
    #1;
    mw = mstep(mw, 1'b1);
    mh = mstep(mh, 1'b0);
    check({tag, "/model_wrap"}, {st_w, en_w, clr_w, ld_w, up_w, lv_w}, mpack(mw));
    check({tag, "/model_halt"}, {st_h, en_h, clr_h, ld_h, up_h, lv_h}, mpack(mh));
  endtask

  task automatic drive(input bit r, input bit t, input bit run, input bit ld,
                       input bit ud, input logic [3:0] din, input logic [13:0] cv);
    rst = r; tick = t; btn_run = run; btn_load = ld; up_down = ud;
    data_in = din; count_val = cv;
  endtask

  typedef struct {
    bit          rst, tick, run, load, ud;
    logic [3:0]  din;
    logic [13:0] cv;
    logic [2:0]  st;
    bit          en, clr, ld, up;
    logic [13:0] lv;
  } vec_t;

  vec_t tbl[$];

  task automatic v(input bit r, input bit t, input bit run, input bit ld, input bit ud,
                   input logic [3:0] din, input logic [13:0] cv, input logic [2:0] st,
                   input bit e_en, input bit e_clr, input bit e_ld, input bit e_up,
                   input logic [13:0] e_lv);
    vec_t x;
    x.rst = r; x.tick = t; x.run = run; x.load = ld; x.ud = ud; x.din = din; x.cv = cv;
    x.st = st; x.en = e_en; x.clr = e_clr; x.ld = e_ld; x.up = e_up; x.lv = e_lv;
    tbl.push_back(x);
  endtask

  task automatic hcheck(input string name, input logic [2:0] st, input bit e_en,
                        input bit e_clr, input bit e_ld);
    check(name, {st_h, en_h, clr_h, ld_h, 1'b0, 14'd0}, {st, e_en, e_clr, e_ld, 1'b0, 14'd0});
  endtask

  initial begin
    mw = '{mode: 0, rp: 0, lp: 0, en: 0, clr: 0, ld: 0, up: 1, lv: 0};
    mh = mw;

    // reset held with run and tick active
    for (int i = 0; i < 4; i++) v(0,1,1,0,0, 0,5,     0,0,0,0,1,0);
    v(1,0,0,0,1, 0,5,     0,0,0,0,1,0);
    // run, three ticks, pause, ticks ignored
    v(1,0,1,0,1, 0,5,     1,0,0,0,1,0);
    v(1,1,1,0,1, 0,5,     1,1,0,0,1,0);
    v(1,0,1,0,1, 0,5,     1,0,0,0,1,0);
    v(1,1,1,0,1, 0,5,     1,1,0,0,1,0);
    v(1,1,1,0,1, 0,5,     1,1,0,0,1,0);
    v(1,0,0,0,1, 0,5,     1,0,0,0,1,0);
    v(1,1,1,0,1, 0,5,     2,0,0,0,1,0);
    v(1,1,1,0,1, 0,5,     2,0,0,0,1,0);
    v(1,1,0,0,1, 0,5,     2,0,0,0,1,0);
    // resume, then loads: 9, 4, clamped 12
    v(1,0,1,0,1, 0,5,     1,0,0,0,1,0);
    v(1,0,0,0,1, 0,5,     1,0,0,0,1,0);
    v(1,0,0,1,1, 9,5,     3,0,0,1,1,9000);
    v(1,0,0,1,1, 9,5,     0,0,0,0,1,9000);
    v(1,0,0,0,1, 4,5,     0,0,0,0,1,9000);
    v(1,0,0,1,1, 4,5,     3,0,0,1,1,4000);
    v(1,0,0,0,1, 4,5,     0,0,0,0,1,4000);
    v(1,0,0,1,1, 12,5,    3,0,0,1,1,9000);
    v(1,0,0,0,1, 12,5,    0,0,0,0,1,9000);
    // wrap handling
    v(1,0,1,0,1, 0,5,     1,0,0,0,1,9000);
    v(1,1,0,0,1, 0,9999,  1,0,1,0,1,9000);
    v(1,0,0,0,1, 0,9999,  1,0,0,0,1,9000);
    v(1,1,0,0,0, 0,0,     1,0,0,1,0,9999);
    v(1,0,0,0,0, 0,0,     1,0,0,0,0,9999);
    v(1,1,0,0,1, 0,10000, 1,0,1,0,1,9999);
    v(1,1,0,0,0, 0,1,     1,1,0,0,0,9999);
    v(1,1,0,0,1, 0,9998,  1,1,0,0,1,9999);
    // simultaneous events, then reset during the load cycle
    v(1,1,1,1,0, 12,5,    3,0,0,1,0,9000);
    v(0,0,0,0,0, 12,5,    0,0,0,0,1,0);
    v(1,1,0,0,1, 0,5,     0,0,0,0,1,0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].tick, tbl[i].run, tbl[i].load, tbl[i].ud, tbl[i].din, tbl[i].cv);
      step($sformatf("vec%0d", i));
      check($sformatf("vec%0d/table", i), {st_w, en_w, clr_w, ld_w, up_w, lv_w},
            {tbl[i].st, tbl[i].en, tbl[i].clr, tbl[i].ld, tbl[i].up, tbl[i].lv});
    end

    // Non-wrapping instance: halt at both limits, exit via run.
    drive(0,0,0,0,1, 0,5);    step("halt_rst");
    drive(1,0,1,0,1, 0,5);    step("halt_run");   hcheck("halt_run",   1,0,0,0);
    drive(1,1,0,0,1, 0,9999); step("halt_top");   hcheck("halt_top",   4,0,0,0);
    drive(1,1,0,0,1, 0,9999); step("halt_tick");  hcheck("halt_tick",  4,0,0,0);
    drive(1,1,0,0,0, 0,0);    step("halt_tick2"); hcheck("halt_tick2", 4,0,0,0);
    drive(1,0,1,0,0, 0,0);    step("halt_exit");  hcheck("halt_exit",  0,0,1,0);
    drive(1,0,0,0,0, 0,0);    step("halt_idle");  hcheck("halt_idle",  0,0,0,0);
    drive(1,0,1,0,0, 0,0);    step("halt_run2");  hcheck("halt_run2",  1,0,0,0);
    drive(1,1,0,0,0, 0,0);    step("halt_bot");   hcheck("halt_bot",   4,0,0,0);
    drive(1,0,0,1,0, 3,0);    step("halt_load");  hcheck("halt_load",  3,0,0,1);
    check("halt_load_val", {7'd0, lv_h}, {7'd0, 14'd3000});

    // Randomised run with boundary-biased count values.
    for (int i = 0; i < 3000; i++) begin
      logic [13:0] cv;
      case ($urandom_range(0, 5))
        0: cv = 14'd0;
        1: cv = 14'd1;
        2: cv = 14'd9998;
        3: cv = 14'd9999;
        default: cv = 14'($urandom_range(0, 16383));
      endcase
      drive(($urandom_range(0, 63) != 0),
            ($urandom_range(0, 2) == 0),
            (($urandom_range(0, 3) == 0) ? ~btn_run : btn_run),
            (($urandom_range(0, 11) == 0) ? ~btn_load : btn_load),
            1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)),
            cv);
      step($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
